// File: rtl/sccb_arbiter_if.sv
// Bundle between the two write requesters, the arbiter and the SCCB engine.
//
// Handshake: a requester raises reqN with addrN/dataN stable and holds it
// until ackN pulses for one cycle. Toward the engine, sccb_start is a one-cycle
// strobe qualified by sccb_ready=1 at grant time; the engine signals
// completion by dropping sccb_ready while busy and raising it when done.
interface sccb_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic [1:0] gnt;
    logic       busy;
    logic       sccb_start;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       sccb_ready;
    logic [2:0] dbg_state;

    // Arbiter side.
    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, sccb_ready,
        output ack0, ack1, err, gnt, busy, sccb_start, sccb_addr, sccb_data,
               dbg_state
    );

    // Requester / SCCB engine side.
    modport master (
        output req0, req1, addr0, addr1, data0, data1, sccb_ready,
        input  ack0, ack1, err, gnt, busy, sccb_start, sccb_addr, sccb_data,
               dbg_state
    );
endinterface

// File: rtl/sccb_arbiter.sv
// Two-port arbiter in front of a single SCCB write engine.
// Port 0 is the ROM config sequencer, port 1 the runtime register writer.
// One SCCB write per grant, completion ack to the owner, err on an engine
// that never goes busy, and an enforced idle gap between transactions.
// Optional feature: define SCCB_ARB_RR_EN for round-robin tie-break
// (default build uses fixed priority, port 0 wins).
module sccb_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sccb_arbiter_if.slave bus
);
    localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The registered ack lands one cycle after the decision, so the decision
    // is taken when the counter is about to reach BUSY_TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             grant;
    logic             done;
    logic             timeout;
    logic             win;     // winning port index when grant is taken

`ifdef SCCB_ARB_RR_EN
    logic last_port;

    // On a tie the port that was not served last wins.
    always_comb begin
        win = ~bus.req0;
        if (bus.req0 && bus.req1) begin
            win = ~last_port;
        end
    end

    // Pointer starts at 1 so port 0 wins the first tie; moves only on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (grant) begin
            last_port <= win;
        end
    end
`else
    // Fixed priority: port 0 whenever it requests.
    always_comb begin
        win = ~bus.req0;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle events.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sccb_ready && (bus.req0 || bus.req1)) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.sccb_ready) begin
                    next_state = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    next_state = GAP;
                end
            end
            WAIT_DONE: begin
                if (bus.sccb_ready) begin
                    done       = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Busy-timeout counter: cleared in ISSUE, saturating count while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT_BUSY && bus.sccb_ready && to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Gap counter runs only while in GAP and is zero everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Grant, latched write payload and registered completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt       <= 2'b00;
            bus.sccb_addr <= 8'h00;
            bus.sccb_data <= 8'h00;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.ack0 <= (done || timeout) && bus.gnt[0];
            bus.ack1 <= (done || timeout) && bus.gnt[1];
            bus.err  <= timeout;
            if (grant) begin
                bus.gnt       <= win ? 2'b10 : 2'b01;
                bus.sccb_addr <= win ? bus.addr1 : bus.addr0;
                bus.sccb_data <= win ? bus.data1 : bus.data0;
            end else if (done || timeout) begin
                bus.gnt <= 2'b00;
            end
        end
    end

    assign bus.sccb_start = (state == ISSUE);
    assign bus.busy       = (state != IDLE);
    assign bus.dbg_state  = state;
endmodule
